acc_lut_arbiter: RTL and testbench
==================================

# acc_lut_arbiter

Shares the single accumulator-constant LUT (5-bit key → 8-bit constant) between `NREQ` requesters. It grants one request at a time, drives the LUT enable and key for exactly one cycle, and registers the returned constant. It returns that constant to the granted requester with a one-cycle response strobe. It sits between the decode/issue stages that need immediate constants (max, 63, 0, 1, 64, 65) and the combinational LUT.

## Interface
- `NREQ`, default 2: number of requesters, legal 1..4.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in NREQ: request present, one bit per requester.
- `req_key` in NREQ×5: key per requester; held stable while `req_valid` is high and `req_ready` is low.
- `req_ready` out NREQ: one-hot grant. A request is accepted on a cycle where `req_valid[i] & req_ready[i]`.
- `lut_en` out 1: LUT enable.
- `lut_key` out 5: LUT key.
- `lut_value` in 8: LUT output, combinational from `lut_en`/`lut_key`.
- `rsp_valid` out NREQ: one-hot, one-cycle response strobe.
- `rsp_value` out 8: registered constant, valid while any `rsp_valid` bit is high.
- `rsp_miss` out 1: key ≥ 6 (undefined entry), qualified by `rsp_valid`.
- `busy` out 1: state ≠ IDLE.

## Operation
- FSM states: IDLE, LOOKUP, RESP.
- IDLE:
  - `req_ready` is the one-hot grant selected from `req_valid`.
  - On accept: latch the grant index and key, go to LOOKUP.
  - With no request, stay in IDLE.
- LOOKUP:
  - `lut_en`=1 and `lut_key`=latched key.
  - At the clock edge: capture `lut_value` into `rsp_value`, and capture `rsp_miss` = (key > 5).
  - Go to RESP.
- RESP:
  - `rsp_valid[grant]`=1 for exactly one cycle.
  - Update the round-robin pointer (see Configuration), go to IDLE.
- `lut_en` is 0 and `lut_key` is 0 in every state except LOOKUP. The LUT never sees a stale key.
- `req_ready` is all-zero outside IDLE. Requests raised during LOOKUP/RESP wait.
- Responses are never dropped. Requesters are always ready to receive `rsp_valid`.
- `rsp_value` holds its last value between responses.
- The arbiter does not interpret values; undefined keys return the LUT's 0 and set `rsp_miss`.
- `NREQ`=1: the grant is simply `req_valid[0]`.

## Timing
- Reset values: state IDLE, grant index 0, RR pointer 0, `rsp_value` 0x00, `rsp_miss` 0, `rsp_valid` 0, `lut_en` 0, `lut_key` 0, `busy` 0.
- `req_ready` in IDLE is combinational from `req_valid` and the pointer.
- Accept at edge t. LOOKUP during cycle t+1. `rsp_valid` and `rsp_value` are visible during cycle t+2. IDLE resumes at cycle t+3.
- Latency is 2 cycles accept-to-response. Throughput is 1 lookup per 3 cycles.
- Simultaneous requests: only the granted requester is accepted. The others keep `req_valid` high and are considered again in the next IDLE cycle.
- A requester may drop `req_valid` before it is accepted without side effects.
- Reset asserted mid-LOOKUP/RESP: immediate return to IDLE with reset values. No response is issued for the in-flight request, and the requester must re-issue it.

## Configuration
- `ACC_LUT_ARB_RR_EN` defined: round-robin arbitration.
  - The search starts at pointer p.
  - After each RESP, p = grant+1 mod NREQ.
- `ACC_LUT_ARB_RR_EN` not defined: fixed priority, lowest index wins. The pointer register is not built.

## Structure
- Shared package `acc_lut_pkg` holds:
  - `ACC_LUT_KEY_W`=5, `ACC_LUT_VAL_W`=8, `ACC_LUT_NKEYS`=6;
  - the `arb_state_t` enum {IDLE, LOOKUP, RESP};
  - named key constants: `KEY_MAX`=0, `KEY_63`=1, `KEY_ZERO`=2, `KEY_ONE`=3, `KEY_64`=4, `KEY_65`=5.
- One sub-module, `acc_lut_rr_pick`:
  - inputs: request vector and pointer;
  - output: one-hot grant;
  - behaviour: rotate-priority-encode when `ACC_LUT_ARB_RR_EN` is defined, lowest-set-bit otherwise.
- The LUT itself is instantiated outside the arbiter, by the parent.

## Test plan
- Reset, then req0 with key 1 accepted at t → `lut_en`=1 only in cycle t+1; at t+2 `rsp_valid`=01, `rsp_value`=0x3F, `rsp_miss`=0.
- req0 key 0 and req1 key 4 raised in the same cycle:
  - round-robin: req0 gets 0xFF, then req1 gets 0x40;
  - round-robin, both held continuously for 4 lookups: grants alternate 0,1,0,1;
  - fixed priority with req0 held: req1 is starved.
- req1 key 9 → `rsp_value`=0x00, `rsp_miss`=1. A following key 5 → 0x41, `rsp_miss`=0.
- `reset` asserted during LOOKUP → in the same cycle `lut_en`=0 and `busy`=0; no `rsp_valid` ever follows; a re-issued key 3 returns 0x01.
- req0 key 2 issued, then a request raised during RESP → `req_ready` stays 0 until IDLE. Back-to-back responses are exactly 3 cycles apart. `rsp_value`=0x00 for key 2.

Source files
------------

// File: rtl/acc_lut_pkg.sv
// Shared types and constants for the accumulator-constant LUT and its arbiter.
package acc_lut_pkg;

  localparam int unsigned ACC_LUT_KEY_W = 5;
  localparam int unsigned ACC_LUT_VAL_W = 8;
  localparam int unsigned ACC_LUT_NKEYS = 6;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    RESP
  } arb_state_t;

  localparam logic [ACC_LUT_KEY_W-1:0] KEY_MAX  = 5'd0;
  localparam logic [ACC_LUT_KEY_W-1:0] KEY_63   = 5'd1;
  localparam logic [ACC_LUT_KEY_W-1:0] KEY_ZERO = 5'd2;
  localparam logic [ACC_LUT_KEY_W-1:0] KEY_ONE  = 5'd3;
  localparam logic [ACC_LUT_KEY_W-1:0] KEY_64   = 5'd4;
  localparam logic [ACC_LUT_KEY_W-1:0] KEY_65   = 5'd5;

  // Keys past the populated table entries read back as 0 and are flagged.
  function automatic logic key_is_miss(input logic [ACC_LUT_KEY_W-1:0] key);
    return key >= ACC_LUT_KEY_W'(ACC_LUT_NKEYS);
  endfunction

endpackage

// File: rtl/acc_lut_rr_pick.sv
// One-hot grant selection: rotating priority from ptr with ACC_LUT_ARB_RR_EN defined,
// otherwise lowest set bit wins and ptr is ignored.
module acc_lut_rr_pick #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned PtrW = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PtrW-1:0] ptr,
  output logic [NREQ-1:0] grant
);

  logic found;

`ifdef ACC_LUT_ARB_RR_EN
  always_comb begin
    grant = '0;
    found = 1'b0;
    // Offset k walks the ring starting at ptr; the first requester found wins.
    for (int unsigned k = 0; k < NREQ; k++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && req[i] && (((32'(ptr) + k) % NREQ) == i)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/acc_lut_arbiter.sv
// Shares the accumulator-constant LUT among NREQ requesters, one lookup per three cycles.
// Define ACC_LUT_ARB_RR_EN for round-robin arbitration; fixed priority otherwise.
module acc_lut_arbiter
  import acc_lut_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NREQ-1:0]                      req_valid,
  input  logic [NREQ-1:0][ACC_LUT_KEY_W-1:0]   req_key,
  output logic [NREQ-1:0]                      req_ready,
  output logic                                 lut_en,
  output logic [ACC_LUT_KEY_W-1:0]             lut_key,
  input  logic [ACC_LUT_VAL_W-1:0]             lut_value,
  output logic [NREQ-1:0]                      rsp_valid,
  output logic [ACC_LUT_VAL_W-1:0]             rsp_value,
  output logic                                 rsp_miss,
  output logic                                 busy
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t                 state_q, state_d;
  logic [PtrW-1:0]            grant_idx_q, grant_idx_d;
  logic [ACC_LUT_KEY_W-1:0]   key_q, key_d;
  logic [ACC_LUT_VAL_W-1:0]   rsp_value_q;
  logic                       rsp_miss_q;
  logic [PtrW-1:0]            rr_ptr;
  logic [NREQ-1:0]            pick_grant;
  logic [PtrW-1:0]            pick_idx;
  logic [ACC_LUT_KEY_W-1:0]   pick_key;
  logic                       accept;

  acc_lut_rr_pick #(
    .NREQ (NREQ),
    .PtrW (PtrW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant)
  );

  always_comb begin
    pick_idx = '0;
    pick_key = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_grant[i]) begin
        pick_idx = PtrW'(i);
        pick_key = req_key[i];
      end
    end
  end

  // The picker only grants asserted requests, so any grant in IDLE is an accept.
  assign accept = (state_q == IDLE) && (|pick_grant);

`ifdef ACC_LUT_ARB_RR_EN
  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == RESP) begin
      rr_ptr_d = (32'(grant_idx_q) == NREQ - 1) ? '0 : grant_idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign rr_ptr = rr_ptr_q;
`else
  assign rr_ptr = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_idx_q <= '0;
      key_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      key_q       <= key_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    key_d       = key_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = LOOKUP;
          grant_idx_d = pick_idx;
          key_d       = pick_key;
        end
      end
      LOOKUP:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response data is held between lookups; only the strobe is one cycle wide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_value_q <= '0;
      rsp_miss_q  <= 1'b0;
    end else if (state_q == LOOKUP) begin
      rsp_value_q <= lut_value;
      rsp_miss_q  <= key_is_miss(key_q);
    end
  end

  always_comb begin
    req_ready = '0;
    lut_en    = 1'b0;
    lut_key   = '0;
    rsp_valid = '0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE: begin
        req_ready = pick_grant;
        busy      = 1'b0;
      end
      LOOKUP: begin
        lut_en  = 1'b1;
        lut_key = key_q;
      end
      RESP: begin
        for (int unsigned i = 0; i < NREQ; i++) begin
          rsp_valid[i] = (32'(grant_idx_q) == i);
        end
      end
      default: busy = 1'b0;
    endcase
  end

  assign rsp_value = rsp_value_q;
  assign rsp_miss  = rsp_miss_q & (state_q == RESP);

endmodule

// File: tb/tb_acc_lut_arbiter.sv
// Self-checking bench for acc_lut_arbiter: scoreboard of expected responses plus per-scenario checks.
module tb_acc_lut_arbiter;
  import acc_lut_pkg::*;

  localparam int unsigned NREQ = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0][4:0]  req_key = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  lut_en;
  logic [4:0]            lut_key;
  logic [7:0]            lut_value;
  logic [NREQ-1:0]       rsp_valid;
  logic [7:0]            rsp_value;
  logic                  rsp_miss;
  logic                  busy;

  typedef struct {
    int         idx;
    logic [7:0] value;
    logic       miss;
    int         cyc;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t rsp_log[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   m_phase = 0;
  int   m_ptr = 0;
  int   m_gidx = 0;
  int   m_g;
  rsp_t m_e;
  rsp_t mon_e;
  rsp_t mon_r;
  logic [NREQ-1:0] m_acc = '0;

  always #5 clk = ~clk;

  acc_lut_arbiter #(
    .NREQ (NREQ)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_key   (req_key),
    .req_ready (req_ready),
    .lut_en    (lut_en),
    .lut_key   (lut_key),
    .lut_value (lut_value),
    .rsp_valid (rsp_valid),
    .rsp_value (rsp_value),
    .rsp_miss  (rsp_miss),
    .busy      (busy)
  );

  function automatic logic [7:0] rom(input logic [4:0] k);
    case (k)
      5'd0:    return 8'hFF;
      5'd1:    return 8'h3F;
      5'd2:    return 8'h00;
      5'd3:    return 8'h01;
      5'd4:    return 8'h40;
      5'd5:    return 8'h41;
      default: return 8'h00;
    endcase
  endfunction

  // Behavioural LUT owned by the parent.
  assign lut_value = lut_en ? rom(lut_key) : 8'h00;

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    int j;
    for (int k = 0; k < NREQ; k++) begin
`ifdef ACC_LUT_ARB_RR_EN
      j = (p + k) % NREQ;
`else
      j = k + (p * 0);
`endif
      if (v[j]) return j;
    end
    return -1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: predicts each grant and queues the response it must produce.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0;
      m_ptr   = 0;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: begin
          m_g = pick(req_valid, m_ptr);
          if (m_g >= 0) begin
            m_e.idx   = m_g;
            m_e.value = rom(req_key[m_g]);
            m_e.miss  = (req_key[m_g] > 5'd5);
            m_e.cyc   = 0;
            exp_q.push_back(m_e);
            m_acc[m_g] = 1'b1;
            m_gidx     = m_g;
            m_phase    = 1;
          end
        end
        1: m_phase = 2;
        default: begin
          m_phase = 0;
`ifdef ACC_LUT_ARB_RR_EN
          m_ptr = (m_gidx + 1) % NREQ;
`endif
        end
      endcase
    end
  end

  // Scoreboard: every response strobe must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (!reset && rsp_valid !== '0) begin
      mon_r.idx = -1;
      for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) mon_r.idx = i;
      mon_r.value = rsp_value;
      mon_r.miss  = rsp_miss;
      mon_r.cyc   = cyc;
      rsp_log.push_back(mon_r);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: rsp_valid=%b with nothing outstanding, required 0", rsp_valid);
      end else begin
        mon_e = exp_q.pop_front();
        if (rsp_valid !== (NREQ'(1) << mon_e.idx) || rsp_value !== mon_e.value ||
            rsp_miss !== mon_e.miss) begin
          n_fail++;
          $display("FAIL sb_response: got valid=%b value=%h miss=%b, required valid=%b value=%h miss=%b",
                   rsp_valid, rsp_value, rsp_miss, NREQ'(1) << mon_e.idx, mon_e.value, mon_e.miss);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic send(input int i, input logic [4:0] k);
    req_key[i]   = k;
    m_acc[i]     = 1'b0;
    req_valid[i] = 1'b1;
    for (int n = 0; n < 20 && !m_acc[i]; n++) tick();
    req_valid[i] = 1'b0;
    if (!m_acc[i]) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: requester %0d not accepted within 20 cycles", i);
    end
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 30; n++) begin
      tick();
      if (m_phase == 0 && exp_q.size() == 0) break;
    end
    if (n == 30) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: arbiter did not drain within 30 cycles");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_req_ready: got %b want 00", req_ready); end
    n_checks++;
    if (lut_en !== 1'b0) begin n_fail++; $display("FAIL rst_lut_en: got %b want 0", lut_en); end
    n_checks++;
    if (lut_key !== 5'd0) begin n_fail++; $display("FAIL rst_lut_key: got %h want 00", lut_key); end
    n_checks++;
    if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 00", rsp_valid); end
    n_checks++;
    if (rsp_value !== 8'h00) begin n_fail++; $display("FAIL rst_rsp_value: got %h want 00", rsp_value); end
    n_checks++;
    if (rsp_miss !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_miss: got %b want 0", rsp_miss); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    req_key[0]   = 5'd1;
    req_valid[0] = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL basic_ready: got %b want 01", req_ready); end
    n_checks++;
    if (lut_en !== 1'b0) begin n_fail++; $display("FAIL basic_en_idle: got %b want 0", lut_en); end
    tick();
    req_valid[0] = 1'b0;
    n_checks++;
    if (lut_en !== 1'b1 || lut_key !== 5'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_lookup: got en=%b key=%h busy=%b want 1 01 1", lut_en, lut_key, busy);
    end
    tick();
    n_checks++;
    if (lut_en !== 1'b0 || rsp_valid !== 2'b01 || rsp_value !== 8'h3F || rsp_miss !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_resp: got en=%b valid=%b value=%h miss=%b want 0 01 3f 0",
               lut_en, rsp_valid, rsp_value, rsp_miss);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_value !== 8'h3F) begin
      n_fail++;
      $display("FAIL basic_after: got valid=%b busy=%b value=%h want 00 0 3f", rsp_valid, busy, rsp_value);
    end
  endtask

  task automatic test_simultaneous();
    int base;
    do_reset();
    base = rsp_log.size();
    fork
      send(0, 5'd0);
      send(1, 5'd4);
    join
    wait_idle();
    n_checks++;
    if (rsp_log.size() != base + 2) begin
      n_fail++;
      $display("FAIL simul_count: got %0d responses want 2", rsp_log.size() - base);
    end else begin
      n_checks++;
      if (rsp_log[base].idx != 0 || rsp_log[base].value !== 8'hFF) begin
        n_fail++;
        $display("FAIL simul_first: got req%0d %h want req0 ff", rsp_log[base].idx, rsp_log[base].value);
      end
      n_checks++;
      if (rsp_log[base+1].idx != 1 || rsp_log[base+1].value !== 8'h40) begin
        n_fail++;
        $display("FAIL simul_second: got req%0d %h want req1 40",
                 rsp_log[base+1].idx, rsp_log[base+1].value);
      end
    end
  endtask

  task automatic test_held();
    int base;
    int want[4];
`ifdef ACC_LUT_ARB_RR_EN
    want = '{0, 1, 0, 1};
`else
    want = '{0, 0, 0, 0};
`endif
    do_reset();
    base       = rsp_log.size();
    req_key[0] = 5'd0;
    req_key[1] = 5'd4;
    req_valid  = 2'b11;
    repeat (12) tick();
    req_valid = 2'b00;
    wait_idle();
    n_checks++;
    if (rsp_log.size() != base + 4) begin
      n_fail++;
      $display("FAIL held_count: got %0d responses want 4", rsp_log.size() - base);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (rsp_log[base+k].idx != want[k]) begin
          n_fail++;
          $display("FAIL held_grant%0d: got req%0d want req%0d", k, rsp_log[base+k].idx, want[k]);
        end
      end
    end
  endtask

  task automatic test_miss();
    int base;
    base = rsp_log.size();
    send(1, 5'd9);
    wait_idle();
    send(1, 5'd5);
    wait_idle();
    n_checks++;
    if (rsp_log.size() != base + 2) begin
      n_fail++;
      $display("FAIL miss_count: got %0d responses want 2", rsp_log.size() - base);
    end else begin
      n_checks++;
      if (rsp_log[base].value !== 8'h00 || rsp_log[base].miss !== 1'b1) begin
        n_fail++;
        $display("FAIL miss_key9: got %h miss=%b want 00 1", rsp_log[base].value, rsp_log[base].miss);
      end
      n_checks++;
      if (rsp_log[base+1].value !== 8'h41 || rsp_log[base+1].miss !== 1'b0) begin
        n_fail++;
        $display("FAIL miss_key5: got %h miss=%b want 41 0",
                 rsp_log[base+1].value, rsp_log[base+1].miss);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    base         = rsp_log.size();
    req_key[0]   = 5'd3;
    req_valid[0] = 1'b1;
    tick();
    req_valid[0] = 1'b0;
    n_checks++;
    if (lut_en !== 1'b1) begin n_fail++; $display("FAIL rmid_lookup: got en=%b want 1", lut_en); end
    reset = 1'b1;
    #1;
    n_checks++;
    if (lut_en !== 1'b0 || busy !== 1'b0 || lut_key !== 5'd0) begin
      n_fail++;
      $display("FAIL rmid_abort: got en=%b busy=%b key=%h want 0 0 00", lut_en, busy, lut_key);
    end
    tick();
    reset = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (rsp_log.size() != base) begin
      n_fail++;
      $display("FAIL rmid_no_rsp: got %0d responses want 0", rsp_log.size() - base);
    end
    send(0, 5'd3);
    wait_idle();
    n_checks++;
    if (rsp_log.size() != base + 1 || rsp_log[rsp_log.size()-1].value !== 8'h01) begin
      n_fail++;
      $display("FAIL rmid_reissue: got %0d responses, last value %h want 1 response 01",
               rsp_log.size() - base, rsp_log.size() > 0 ? rsp_log[rsp_log.size()-1].value : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    base         = rsp_log.size();
    req_key[0]   = 5'd2;
    req_valid[0] = 1'b1;
    tick();
    req_valid[0] = 1'b0;
    tick();
    req_key[1]   = 5'd0;
    req_valid[1] = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_resp_ready: got ready=%b valid=%b want 00 01", req_ready, rsp_valid);
    end
    tick();
    n_checks++;
    if (req_ready !== 2'b10) begin n_fail++; $display("FAIL b2b_idle_ready: got %b want 10", req_ready); end
    tick();
    req_valid[1] = 1'b0;
    wait_idle();
    n_checks++;
    if (rsp_log.size() != base + 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d responses want 2", rsp_log.size() - base);
    end else begin
      n_checks++;
      if (rsp_log[base].value !== 8'h00 || rsp_log[base].idx != 0) begin
        n_fail++;
        $display("FAIL b2b_key2: got req%0d %h want req0 00", rsp_log[base].idx, rsp_log[base].value);
      end
      n_checks++;
      if (rsp_log[base+1].cyc - rsp_log[base].cyc != 3) begin
        n_fail++;
        $display("FAIL b2b_spacing: got %0d cycles want 3", rsp_log[base+1].cyc - rsp_log[base].cyc);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_simultaneous();
    test_held();
    test_miss();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d outstanding responses want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
